// File: rtl/config_chain_loader.sv
// Master end of a tile configuration shift chain: serialises handshaked bitstream
// words LSB-first into the chain and gathers the bits leaving its last stage.
module config_chain_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 36,
  parameter int COUNT_WIDTH  = 6
) (
  input  logic                  config_clock,
  input  logic                  config_nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  chain_data,
  output logic                  chain_enable,
  input  logic                  chain_return,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(WORD_WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(CHAIN_LENGTH);

  typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

  state_t                  state, state_d;
  logic [COUNT_WIDTH-1:0]  remaining, remaining_d;
  logic [IDX_W-1:0]        bit_idx, bit_idx_d;
  logic [WORD_WIDTH-1:0]   shreg, shreg_d, shifted;
  logic [WORD_WIDTH-1:0]   rb_acc, rb_acc_d, rb_acc_ins;
  logic                    word_ready_d, chain_data_d, chain_enable_d;
  logic [WORD_WIDTH-1:0]   rb_data_d;
  logic                    rb_valid_d, busy_d, done_d;

  always_comb begin
    state_d        = state;
    remaining_d    = remaining;
    bit_idx_d      = bit_idx;
    shreg_d        = shreg;
    rb_acc_d       = rb_acc;
    word_ready_d   = 1'b0;
    chain_data_d   = 1'b0;
    chain_enable_d = 1'b0;
    rb_data_d      = rb_data;
    rb_valid_d     = 1'b0;
    done_d         = 1'b0;
    shifted        = shreg >> 1;
    rb_acc_ins     = rb_acc;
    rb_acc_ins[bit_idx] = chain_return;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_d      = WAIT_WORD;
            remaining_d  = FULL_COUNT;
            word_ready_d = 1'b1;
          end
        end
        WAIT_WORD: begin
          if (word_valid && word_ready) begin
            state_d        = SHIFT;
            shreg_d        = word_data;
            bit_idx_d      = '0;
            rb_acc_d       = '0;
            chain_data_d   = word_data[0];
            chain_enable_d = 1'b1;
          end else begin
            word_ready_d = 1'b1;
          end
        end
        SHIFT: begin
          // Every SHIFT edge is a chain capture edge: the outgoing bit is the chain's last stage.
          remaining_d = remaining - COUNT_WIDTH'(1);
          rb_acc_d    = rb_acc_ins;
          if (bit_idx == LAST_IDX || remaining == COUNT_WIDTH'(1)) begin
            rb_data_d  = rb_acc_ins;
            rb_valid_d = 1'b1;
            if (remaining == COUNT_WIDTH'(1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d      = WAIT_WORD;
              word_ready_d = 1'b1;
            end
          end else begin
            bit_idx_d      = bit_idx + IDX_W'(1);
            shreg_d        = shifted;
            chain_data_d   = shifted[0];
            chain_enable_d = 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      state        <= IDLE;
      remaining    <= '0;
      bit_idx      <= '0;
      word_ready   <= 1'b0;
      chain_data   <= 1'b0;
      chain_enable <= 1'b0;
      rb_data      <= '0;
      rb_valid     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      remaining    <= remaining_d;
      bit_idx      <= bit_idx_d;
      word_ready   <= word_ready_d;
      chain_data   <= chain_data_d;
      chain_enable <= chain_enable_d;
      rb_data      <= rb_data_d;
      rb_valid     <= rb_valid_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  // Datapath registers are always overwritten before use, so they carry no reset.
  always_ff @(posedge config_clock) begin
    shreg  <= shreg_d;
    rb_acc <= rb_acc_d;
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: a behavioural chain model plus bit-placement and
// readback expectations computed directly from the load order.
module tb_config_chain_loader;
  localparam int WW = 8;
  localparam int CL = 36;
  localparam int CW = 6;
  localparam int NW = (CL + WW - 1) / WW;

  logic          config_clock = 1'b0;
  logic          config_nreset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [WW-1:0] word_data = '0;
  logic          word_valid = 1'b0;
  logic          word_ready, chain_data, chain_enable, chain_return;
  logic [WW-1:0] rb_data;
  logic          rb_valid, busy, done;

  logic [CL-1:0] chain;
  logic [CL-1:0] preload_val = '0;
  logic          preload_req = 1'b0;

  int checks = 0, failures = 0;
  int en_total = 0, cur_run = 0, run_cnt = 0, rb_cnt = 0, done_total = 0, overlap = 0;
  int            run_log [256];
  logic [WW-1:0] rb_log  [256];

  always #5 config_clock = ~config_clock;

  config_chain_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL), .COUNT_WIDTH(CW)) dut (
    .config_clock(config_clock), .config_nreset(config_nreset),
    .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .chain_data(chain_data), .chain_enable(chain_enable), .chain_return(chain_return),
    .rb_data(rb_data), .rb_valid(rb_valid), .busy(busy), .done(done)
  );

  // Chain model: config_in enters stage 0, the highest stage drives config_out.
  assign chain_return = chain[CL-1];
  always @(posedge config_clock) begin
    if (preload_req) chain <= preload_val;
    else if (chain_enable) chain <= {chain[CL-2:0], chain_data};
  end

  always @(negedge config_clock) begin
    if (chain_enable === 1'b1) begin
      en_total++;
      cur_run++;
    end else if (cur_run > 0) begin
      run_log[run_cnt % 256] = cur_run;
      run_cnt++;
      cur_run = 0;
    end
    if (rb_valid === 1'b1) begin
      rb_log[rb_cnt % 256] = rb_data;
      rb_cnt++;
    end
    if (done === 1'b1) done_total++;
    if (word_ready === 1'b1 && chain_enable === 1'b1) overlap++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge config_clock);
    #1;
  endtask

  task automatic preload(input logic [CL-1:0] v);
    preload_val = v;
    preload_req = 1'b1;
    tick();
    preload_req = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    while (word_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    check($sformatf("%s_ready_wait", tag), word_ready, 1);
  endtask

  task automatic send_word(input logic [WW-1:0] w, input int bp, input string tag);
    int en0;
    word_data  = w;
    word_valid = (bp == 0);
    wait_ready(tag);
    if (bp > 0) begin
      en0 = en_total;
      repeat (bp) tick();
      check($sformatf("%s_bp_ready", tag), word_ready, 1);
      check($sformatf("%s_bp_enable", tag), chain_enable, 0);
      check($sformatf("%s_bp_no_shift", tag), en_total - en0, 0);
      word_valid = 1'b1;
    end
    tick();
    check($sformatf("%s_first_bit", tag), {chain_enable, chain_data}, {1'b1, w[0]});
    check($sformatf("%s_ready_low", tag), word_ready, 0);
  endtask

  task automatic full_load(input string name, input logic [WW-1:0] w [NW],
                           input int bp_word, input bit poke_start);
    logic [CL-1:0] old_chain, exp_chain;
    logic [WW-1:0] exp_rb;
    int run_base, rb_base, en_base, done_base, ov_base, k, t, exp_len;
    old_chain = chain;
    run_base = run_cnt; rb_base = rb_cnt; en_base = en_total;
    done_base = done_total; ov_base = overlap;
    start = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("%s_busy_start", name), busy, 1);
    for (int j = 0; j < NW; j++) begin
      send_word(w[j], (j == bp_word) ? 10 : 0, $sformatf("%s_w%0d", name, j));
      if (poke_start && j == 1) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("%s_poke_busy", name), busy, 1);
        check($sformatf("%s_poke_enable", name), chain_enable, 1);
      end
    end
    t = 0;
    while (done !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    word_valid = 1'b0;
    check($sformatf("%s_done_pulse", name), done, 1);
    tick();
    check($sformatf("%s_busy_after_done", name), {busy, done}, 0);

    for (int j = 0; j < CL; j++) exp_chain[CL-1-j] = w[j / WW][j % WW];
    check($sformatf("%s_enable_cycles", name), en_total - en_base, CL);
    check($sformatf("%s_done_count", name), done_total - done_base, 1);
    check($sformatf("%s_run_count", name), run_cnt - run_base, NW);
    check($sformatf("%s_rb_count", name), rb_cnt - rb_base, NW);
    check($sformatf("%s_ready_overlap", name), overlap - ov_base, 0);
    for (int j = 0; j < NW; j++) begin
      exp_len = (CL - j * WW < WW) ? CL - j * WW : WW;
      check($sformatf("%s_run%0d", name, j), run_log[(run_base + j) % 256], exp_len);
      exp_rb = '0;
      for (int i = 0; i < WW; i++) begin
        k = j * WW + i;
        if (k < CL) exp_rb[i] = old_chain[CL-1-k];
      end
      check($sformatf("%s_rb%0d", name, j), rb_log[(rb_base + j) % 256], exp_rb);
    end
    check($sformatf("%s_chain", name), chain, exp_chain);
  endtask

  initial begin
    logic [WW-1:0] w_plan [NW] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h0B};
    logic [WW-1:0] w_zero [NW] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [WW-1:0] w_rnd  [NW];
    logic [63:0]   r;
    int rb0, en0, d0;

    #2 config_nreset = 1'b0;
    #1;
    check("reset_outputs", {word_ready, chain_data, chain_enable, rb_data, rb_valid, busy, done}, 0);
    tick();
    tick();
    config_nreset = 1'b1;
    tick();
    check("idle_after_reset", {busy, word_ready, chain_enable}, 0);

    r = {$urandom(), $urandom()};
    preload(r[CL-1:0]);
    full_load("plan", w_plan, -1, 1'b0);
    check("plan_bit35", chain[CL-1], 1);
    check("plan_bits3_0", chain[3:0], 4'b1101);

    preload('1);
    full_load("ones_rb", w_zero, -1, 1'b0);
    check("ones_rb_last", rb_log[(rb_cnt - 1) % 256], 8'h0F);
    full_load("zero_rb", w_zero, -1, 1'b0);

    for (int j = 0; j < NW; j++) w_rnd[j] = WW'($urandom());
    full_load("backpressure", w_rnd, 2, 1'b0);

    for (int j = 0; j < NW; j++) w_rnd[j] = WW'($urandom());
    full_load("start_in_shift", w_rnd, -1, 1'b1);

    en0 = en_total;
    word_valid = 1'b1;
    word_data = 8'h5A;
    repeat (3) tick();
    check("idle_valid_ignored", {busy, word_ready, chain_enable}, 0);
    check("idle_valid_no_shift", en_total - en0, 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    word_valid = 1'b0;
    check("abort_beats_start", {busy, word_ready}, 0);

    for (int j = 0; j < NW; j++) w_rnd[j] = WW'($urandom());
    rb0 = rb_cnt; en0 = en_total; d0 = done_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(w_rnd[0], 0, "abort_w0");
    send_word(w_rnd[1], 0, "abort_w1");
    tick();
    tick();
    check("abort_third_bit", {chain_enable, chain_data}, {1'b1, w_rnd[1][2]});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    word_valid = 1'b0;
    check("abort_outputs", {busy, chain_enable, chain_data, word_ready, done, rb_valid}, 0);
    tick();
    tick();
    check("abort_no_done", done_total - d0, 0);
    check("abort_no_rb", rb_cnt - rb0, 1);
    check("abort_enable_cycles", en_total - en0, 11);
    for (int j = 0; j < NW; j++) w_rnd[j] = WW'($urandom());
    full_load("after_abort", w_rnd, -1, 1'b0);

    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(8'hC3, 0, "rst_w0");
    tick();
    tick();
    @(posedge config_clock);
    #2 config_nreset = 1'b0;
    #1;
    check("async_reset_outputs",
          {word_ready, chain_data, chain_enable, rb_data, rb_valid, busy, done}, 0);
    word_valid = 1'b0;
    tick();
    config_nreset = 1'b1;
    tick();
    check("after_reset_idle", {busy, word_ready, chain_enable}, 0);
    for (int j = 0; j < NW; j++) w_rnd[j] = WW'($urandom());
    full_load("after_reset", w_rnd, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
